obi_dcache_arbiter: RTL
=======================

Name: obi_dcache_arbiter

Overview:
- Shares one dcache_core request port between two OBI requesters:
  - m0: scalar CPU data port.
  - m1: vector coprocessor load/store unit.
- Round-robin arbitration on the address phase.
- Tracks outstanding transactions in an in-order ID FIFO and routes each dcache response to its originator.
- Sequences a vector-initiated cache flush: drain, flush, wait, done.

Parameters:
- MAX_OUTST, 4: max outstanding dcache transactions; power of 2, 2..16.
- CACHEABLE_LIMIT, 32'h8000_0000: addresses strictly below this are cacheable.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- m0_req_i, m1_req_i  in  1  OBI request
- m0_gnt_o, m1_gnt_o  out  1  OBI grant
- m0_we_i, m1_we_i  in  1  write enable
- m0_be_i, m1_be_i  in  4  byte enables
- m0_addr_i, m1_addr_i  in  32  address
- m0_wdata_i, m1_wdata_i  in  32  write data
- m0_rvalid_o, m1_rvalid_o  out  1  response valid
- m0_rdata_o, m1_rdata_o  out  32  read data
- m0_err_o, m1_err_o  out  1  response error, qualified by rvalid
- flush_req_i  in  1  single-cycle flush request, from vector unit
- flush_busy_o  out  1  high from flush_req_i acceptance until done
- flush_done_o  out  1  one-cycle pulse when the flush completes
- mem_addr_o  out  32  dcache address
- mem_data_wr_o  out  32  dcache write data
- mem_rd_o  out  1  dcache read strobe
- mem_wr_o  out  4  dcache write byte strobes
- mem_cacheable_o  out  1  (mem_addr_o < CACHEABLE_LIMIT)
- mem_req_tag_o  out  11  {10'b0, owner id}
- mem_invalidate_o, mem_writeback_o  out  1  tied 0
- mem_flush_o  out  1  dcache flush request
- mem_data_rd_i  in  32  dcache read data
- mem_accept_i  in  1  dcache accepts request
- mem_ack_i  in  1  dcache response
- mem_error_i  in  1  dcache response error
- mem_resp_tag_i  in  11  response tag (unused by default)

Behaviour:
- Reset (rst_ni=0 at posedge):
  - State=ARB, rr pointer=m0 preferred, FIFO empty, count=0.
  - All outputs 0 while rst_ni is low.
  - Reset mid-transaction discards in-flight responses: acks arriving after reset with an empty FIFO are dropped, no rvalid.
- FSM states: ARB, DRAIN, FLUSH, FWAIT.
- ARB:
  - Selection: if exactly one requester has req high, select it. If both, select the rr-preferred one.
  - Drive mem_rd_o = req & ~we, mem_wr_o = we ? be : 0 for the selected requester; address and data are combinational from it.
  - Requests are suppressed (mem_rd_o=0, mem_wr_o=0) when count==MAX_OUTST. No grant is given on a full FIFO, even if an ack pops in the same cycle.
  - Grant: gnt_o of the selected requester = mem_accept_i & ~full. Grant and accept are the same cycle.
  - On grant: push owner id; rr preference moves to the other requester.
- Responses:
  - On mem_ack_i while in ARB or DRAIN with FIFO non-empty: pop the head id.
  - Drive rvalid/rdata/err of that requester in the same cycle, combinational from mem_*_i. rdata=0 for the non-owner.
  - Simultaneous push and pop: count unchanged.
- Flush sequencing:
  - flush_req_i in ARB: go to DRAIN next cycle, flush_busy_o=1. The grant in that same cycle still completes.
  - flush_req_i is ignored while flush_busy_o=1.
  - DRAIN: no grants, no mem_rd/wr. When count==0, go to FLUSH.
  - FLUSH: mem_flush_o=1 until mem_accept_i; then go to FWAIT.
  - FWAIT: the next mem_ack_i is the flush completion. It is not routed to any requester and does not pop the FIFO. Pulse flush_done_o and return to ARB; flush_busy_o drops the same cycle.
- Pending OBI requests stay stalled (gnt=0) through DRAIN/FLUSH/FWAIT. Requesters must hold req/addr/data stable until gnt.
- mem_error_i on a flush ack is ignored.
- Ack with empty FIFO in ARB: dropped. Flagged by assertion in simulation.

Optional Feature:
- Macro OBI_ARB_PERF_CNT_EN.
- Defined:
  - Adds ports m0_gnt_cnt_o, m1_gnt_cnt_o (out, 32) and stall_cnt_o (out, 32).
  - Grant counters increment per grant, wrapping at 2^32.
  - stall_cnt_o increments each cycle any req is high without a grant.
  - All counters clear on reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package obi_arb_pkg:
  - typedef owner_e {OWNER_CPU=1'b0, OWNER_VEC=1'b1}.
  - typedef arb_state_e {ARB, DRAIN, FLUSH, FWAIT}.
  - localparam TAG_W=11.
- Sub-module obi_arb_id_fifo: depth MAX_OUTST, 1-bit data, push/pop/count/full/empty, simultaneous push+pop allowed.

Test Plan:
- m0 read at 0x0000_1000, mem_accept_i=1, ack 2 cycles later with data 0xDEADBEEF -> m0_gnt_o=1 in cycle 0, m0_rvalid_o=1 with rdata 0xDEADBEEF, m1_rvalid_o=0; mem_cacheable_o=1.
- m0 and m1 both request continuously, accept=1 every cycle -> grants alternate m0,m1,m0,m1; first grant goes to m0 after reset.
- Responses out of requester order in issue:
  - Issue m1 write to 0x8000_0010 with be=4'b0011, then m0 read.
  - Acks in order -> first ack raises m1_rvalid_o, second raises m0_rvalid_o.
  - mem_wr_o=4'b0011 and mem_cacheable_o=0 for the write.
- Hold acks with MAX_OUTST=4: 4 grants -> 5th request sees gnt=0 and mem_rd_o=0. Ack and new request in the same cycle -> no grant that cycle; grant the following cycle.
- flush_req_i pulse with 2 outstanding:
  - DRAIN holds gnt=0 until both acks.
  - mem_flush_o asserts until accept; flush ack yields flush_done_o pulse with no rvalid.
  - A pending m0 request is granted the cycle after done.
- rst_ni low for 1 cycle with 3 outstanding -> all outputs 0; later acks produce no rvalid; the next request is granted normally.

Source files
------------

// File: rtl/obi_arb_pkg.sv
// Shared types for the OBI dcache arbiter: requester ids, arbiter states, tag width.
// Optional performance counters in the top are enabled with OBI_ARB_PERF_CNT_EN.
package obi_arb_pkg;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_VEC = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        ARB,
        DRAIN,
        FLUSH,
        FWAIT
    } arb_state_e;

    localparam int unsigned TAG_W = 11;

    // The round-robin pointer always hands preference to the requester not just served.
    function automatic owner_e other_owner(input owner_e o);
        return (o == OWNER_CPU) ? OWNER_VEC : OWNER_CPU;
    endfunction

endpackage

// File: rtl/obi_arb_id_fifo.sv
// In-order FIFO of owner ids for outstanding dcache transactions.
// DEPTH must be a power of two; push and pop may happen in the same cycle.
module obi_arb_id_fifo
    import obi_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  owner_e                 push_id_i,
    input  logic                   pop_i,
    output owner_e                 pop_id_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    owner_e           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o   = (count_q == CNT_W'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign count_o  = count_q;
    assign do_pop   = pop_i & ~empty_o;
    assign do_push  = push_i & (~full_o | do_pop);
    assign pop_id_o = mem_q[rd_ptr_q];

    // Next pointer and occupancy values.
    always_comb begin
        // NOTE: every variable gets a default first so no path through the block infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers, synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Id storage.
    always_ff @(posedge clk_i) begin
        // NOTE: storage is not reset; an entry is only read after the count says it was written.
        if (do_push) mem_q[wr_ptr_q] <= push_id_i;
    end

endmodule

// File: rtl/obi_dcache_arbiter.sv
// Shares one dcache request port between the scalar CPU (m0) and the vector unit (m1):
// round-robin address-phase arbitration, in-order response routing through an id FIFO,
// and a drain/flush/wait sequence for vector-initiated cache flushes.
// Define OBI_ARB_PERF_CNT_EN to add grant and stall counters.
module obi_dcache_arbiter
    import obi_arb_pkg::*;
#(
    parameter int unsigned MAX_OUTST       = 4,
    parameter logic [31:0] CACHEABLE_LIMIT = 32'h8000_0000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             m0_req_i,
    output logic             m0_gnt_o,
    input  logic             m0_we_i,
    input  logic [3:0]       m0_be_i,
    input  logic [31:0]      m0_addr_i,
    input  logic [31:0]      m0_wdata_i,
    output logic             m0_rvalid_o,
    output logic [31:0]      m0_rdata_o,
    output logic             m0_err_o,
    input  logic             m1_req_i,
    output logic             m1_gnt_o,
    input  logic             m1_we_i,
    input  logic [3:0]       m1_be_i,
    input  logic [31:0]      m1_addr_i,
    input  logic [31:0]      m1_wdata_i,
    output logic             m1_rvalid_o,
    output logic [31:0]      m1_rdata_o,
    output logic             m1_err_o,
    input  logic             flush_req_i,
    output logic             flush_busy_o,
    output logic             flush_done_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_data_wr_o,
    output logic             mem_rd_o,
    output logic [3:0]       mem_wr_o,
    output logic             mem_cacheable_o,
    output logic [TAG_W-1:0] mem_req_tag_o,
    output logic             mem_invalidate_o,
    output logic             mem_writeback_o,
    output logic             mem_flush_o,
    input  logic [31:0]      mem_data_rd_i,
    input  logic             mem_accept_i,
    input  logic             mem_ack_i,
    input  logic             mem_error_i,
    input  logic [TAG_W-1:0] mem_resp_tag_i
`ifdef OBI_ARB_PERF_CNT_EN
    ,
    output logic [31:0]      m0_gnt_cnt_o,
    output logic [31:0]      m1_gnt_cnt_o,
    output logic [31:0]      stall_cnt_o
`endif
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTST) + 1;

    arb_state_e       state_q, state_d;
    owner_e           rr_q, rr_d;

    owner_e           sel;
    logic             sel_req, sel_we;
    logic [3:0]       sel_be;
    logic [31:0]      sel_addr, sel_wdata;

    logic             issue, grant, pop, flush_ack, resp_cpu, resp_vec;
    logic             fifo_full, fifo_empty;
    owner_e           head_id;
    logic [CNT_W-1:0] fifo_count;

    // Response tags are not needed: responses return in issue order.
    logic             unused_resp_tag;
    assign unused_resp_tag = ^mem_resp_tag_i;

    assign mem_invalidate_o = 1'b0;
    assign mem_writeback_o  = 1'b0;

    // Pick the requester for this cycle's address phase.
    always_comb begin
        if (m0_req_i && m1_req_i) sel = rr_q;
        else if (m1_req_i)        sel = OWNER_VEC;
        else                      sel = OWNER_CPU;

        if (sel == OWNER_VEC) begin
            sel_req   = m1_req_i;
            sel_we    = m1_we_i;
            sel_be    = m1_be_i;
            sel_addr  = m1_addr_i;
            sel_wdata = m1_wdata_i;
        end else begin
            sel_req   = m0_req_i;
            sel_we    = m0_we_i;
            sel_be    = m0_be_i;
            sel_addr  = m0_addr_i;
            sel_wdata = m0_wdata_i;
        end
    end

    // A full FIFO blocks issue even if an ack frees a slot this cycle,
    // keeping the grant path independent of mem_ack_i.
    assign issue     = (state_q == ARB) & sel_req & ~fifo_full;
    assign grant     = issue & mem_accept_i;
    assign pop       = mem_ack_i & ((state_q == ARB) | (state_q == DRAIN)) & ~fifo_empty;
    assign flush_ack = (state_q == FWAIT) & mem_ack_i;
    assign resp_cpu  = pop & (head_id == OWNER_CPU);
    assign resp_vec  = pop & (head_id == OWNER_VEC);

    obi_arb_id_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_id_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_i    (grant),
        .push_id_i (sel),
        .pop_i     (pop),
        .pop_id_o  (head_id),
        .count_o   (fifo_count),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // Next state and round-robin preference.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        if (grant) rr_d = other_owner(sel);
        case (state_q)
            ARB:     if (flush_req_i)        state_d = DRAIN;
            DRAIN:   if (fifo_count == '0)   state_d = FLUSH;
            FLUSH:   if (mem_accept_i)       state_d = FWAIT;
            FWAIT:   if (mem_ack_i)          state_d = ARB;
            default:                         state_d = ARB;
        endcase
    end

    // State and round-robin registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ARB;
            rr_q    <= OWNER_CPU;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
        end
    end

    // Output drive, forced to zero while reset is held.
    always_comb begin
        m0_gnt_o        = 1'b0;
        m1_gnt_o        = 1'b0;
        m0_rvalid_o     = 1'b0;
        m1_rvalid_o     = 1'b0;
        m0_rdata_o      = '0;
        m1_rdata_o      = '0;
        m0_err_o        = 1'b0;
        m1_err_o        = 1'b0;
        mem_addr_o      = '0;
        mem_data_wr_o   = '0;
        mem_rd_o        = 1'b0;
        mem_wr_o        = '0;
        mem_cacheable_o = 1'b0;
        mem_req_tag_o   = '0;
        mem_flush_o     = 1'b0;
        flush_busy_o    = 1'b0;
        flush_done_o    = 1'b0;
        if (rst_ni) begin
            m0_gnt_o        = grant & (sel == OWNER_CPU);
            m1_gnt_o        = grant & (sel == OWNER_VEC);
            m0_rvalid_o     = resp_cpu;
            m1_rvalid_o     = resp_vec;
            m0_rdata_o      = resp_cpu ? mem_data_rd_i : '0;
            m1_rdata_o      = resp_vec ? mem_data_rd_i : '0;
            m0_err_o        = resp_cpu & mem_error_i;
            m1_err_o        = resp_vec & mem_error_i;
            mem_addr_o      = sel_addr;
            mem_data_wr_o   = sel_wdata;
            mem_rd_o        = issue & ~sel_we;
            mem_wr_o        = (issue & sel_we) ? sel_be : 4'b0000;
            mem_cacheable_o = (sel_addr < CACHEABLE_LIMIT);
            mem_req_tag_o   = {{(TAG_W-1){1'b0}}, sel};
            mem_flush_o     = (state_q == FLUSH);
            flush_busy_o    = (state_q != ARB) & ~flush_ack;
            flush_done_o    = flush_ack;
        end
    end

`ifdef OBI_ARB_PERF_CNT_EN
    logic [31:0] m0_gnt_cnt_q, m0_gnt_cnt_d;
    logic [31:0] m1_gnt_cnt_q, m1_gnt_cnt_d;
    logic [31:0] stall_cnt_q,  stall_cnt_d;

    // Grant counters and stall counter, all wrapping at 2^32.
    always_comb begin
        m0_gnt_cnt_d = m0_gnt_cnt_q;
        m1_gnt_cnt_d = m1_gnt_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (grant && sel == OWNER_CPU) m0_gnt_cnt_d = m0_gnt_cnt_q + 32'd1;
        if (grant && sel == OWNER_VEC) m1_gnt_cnt_d = m1_gnt_cnt_q + 32'd1;
        if ((m0_req_i || m1_req_i) && !grant) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // Counter registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            m0_gnt_cnt_q <= '0;
            m1_gnt_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            m0_gnt_cnt_q <= m0_gnt_cnt_d;
            m1_gnt_cnt_q <= m1_gnt_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign m0_gnt_cnt_o = rst_ni ? m0_gnt_cnt_q : '0;
    assign m1_gnt_cnt_o = rst_ni ? m1_gnt_cnt_q : '0;
    assign stall_cnt_o  = rst_ni ? stall_cnt_q  : '0;
`endif

`ifndef SYNTHESIS
    // Acks for transactions cut off by reset are expected leftovers; any other ack
    // arriving with an empty FIFO in ARB is a dcache protocol error.
    logic [7:0] orphan_q, orphan_d;
    logic       empty_ack;

    assign empty_ack = mem_ack_i & (state_q == ARB) & fifo_empty;

    // Number of reset-discarded transactions still owed an ack.
    always_comb begin
        orphan_d = orphan_q;
        if (!rst_ni)                          orphan_d = orphan_q + 8'(fifo_count);
        else if (empty_ack && orphan_q != '0) orphan_d = orphan_q - 8'd1;
    end

    // Orphan counter register.
    always_ff @(posedge clk_i) begin
        orphan_q <= orphan_d;
    end

    // Flag unexpected dropped acks.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!empty_ack || orphan_q != '0)
                else $error("obi_dcache_arbiter: dcache ack with empty id fifo dropped");
        end
    end
`endif

endmodule
